// File: rtl/bip_pkg.sv
// Shared BIP definitions: instruction field widths, HALT opcode, loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bip_pkg;

    // Instruction layout: [15:11] opcode, [10:0] operand.
    localparam int OPCODE_W  = 5;
    localparam int OPERAND_W = 11;

    localparam logic [OPCODE_W-1:0] HALT_OPC = 5'b00000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_HI = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/bip_program_loader.sv
// Loads BIP program memory from a UART byte stream (high byte first) and
// releases the CPU once the HALT word is stored.
// Latency: prog_we one cycle after the low-byte rx_done; cpu_enable one cycle after the HALT write.
// Backpressure: none; every byte is accepted in WAIT_HI/WAIT_LO and in WRITE
// (unless the word being written ends the load), ignored in IDLE/DONE/ERROR.
//
// Ports:
//   clk, reset                 system clock, async active-high reset
//   start                      one-cycle pulse, begins/restarts a load (beats rx_done)
//   rx_data, rx_done           received byte and its one-cycle strobe
//   prog_we/addr/wdata         registered program-memory write port
//   busy, cpu_enable, load_err load status (all registered)
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int                  ADDR_W      = 11,
    parameter int                  INSTR_W     = 16,
    parameter int                  MEM_DEPTH   = 2048,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    output logic               prog_we,
    output logic [ADDR_W-1:0]  prog_addr,
    output logic [INSTR_W-1:0] prog_wdata,
    output logic               busy,
    output logic               cpu_enable,
    output logic               load_err
);

    loader_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [7:0]         hi_q,    hi_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q,    we_d;
    logic               busy_q,  busy_d;
    logic               cpu_en_q, cpu_en_d;
    logic               err_q,   err_d;

    logic               is_halt;
    logic               is_last;

    // Decisions in WRITE look at the word being written this cycle.
    assign is_halt = (wdata_q[OPERAND_W +: OPCODE_W] == HALT_OPCODE);
    assign is_last = (addr_q == ADDR_W'(MEM_DEPTH - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        wdata_d = wdata_q;

        if (start) begin
            // Restart from any state; a half-received word is simply abandoned.
            state_d = ST_WAIT_HI;
            addr_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT_HI: begin
                    if (rx_done) begin
                        hi_d    = rx_data;
                        state_d = ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (rx_done) begin
                        wdata_d = INSTR_W'({hi_q, rx_data});
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (is_halt) begin
                        state_d = ST_DONE;
                    end else if (is_last) begin
                        // Counter stops here rather than wrapping onto word 0.
                        state_d = ST_ERROR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (rx_done) begin
                            // Byte arriving during the write is the next high byte.
                            hi_d    = rx_data;
                            state_d = ST_WAIT_LO;
                        end else begin
                            state_d = ST_WAIT_HI;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        we_d     = (state_d == ST_WRITE);
        busy_d   = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO) ||
                   (state_d == ST_WRITE);
        cpu_en_d = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            hi_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            cpu_en_q <= cpu_en_d;
            err_q    <= err_d;
        end
    end

    assign prog_we    = we_q;
    assign prog_addr  = addr_q;
    assign prog_wdata = wdata_q;
    assign busy       = busy_q;
    assign cpu_enable = cpu_en_q;
    assign load_err   = err_q;

endmodule
